// File: rtl/ov5640_pkg.sv
// Shared types and constants for the OV5640 SCCB write master.
package ov5640_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    ACK,
    STOP,
    GAP
  } sccb_state_t;

  localparam int         SCCB_BYTES      = 4;
  localparam logic [7:0] OV5640_DEV_ADDR = 8'h78;

  // One queued register write
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } sccb_cmd_t;

endpackage

// File: rtl/sccb_qtick_gen.sv
// Quarter-bit timebase: divider 0..CLK_DIV-1 plus a 2-bit quarter index.
module sccb_qtick_gen #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,    // count only while a transaction is active
  input  logic       clr_i,   // restart divider and quarter index
  input  logic       qclr_i,  // next quarter index is 0 (state change on this qtick)
  output logic       qtick_o,
  output logic [1:0] qcnt_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_q;
  logic [1:0]    q_q;

  assign qtick_o = en_i && (div_q == DW'(CLK_DIV - 1));
  assign qcnt_o  = q_q;

  // Divider wraps on qtick; quarter index advances or restarts with it
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      div_q <= '0;
      q_q   <= '0;
    end else if (en_i) begin
      if (qtick_o) begin
        div_q <= '0;
        q_q   <= qclr_i ? 2'd0 : q_q + 2'd1;
      end else begin
        div_q <= div_q + DW'(1);
      end
    end
  end

endmodule

// File: rtl/sccb_master_ov5640.sv
// SCCB 3-phase write master: 2-entry command queue feeding a quarter-bit
// sequenced START / 4 bytes + X bit / STOP / bus-free GAP engine.
module sccb_master_ov5640 import ov5640_pkg::*; #(
  parameter int         CLK_DIV      = 125,
  parameter logic [7:0] DEV_ADDR     = OV5640_DEV_ADDR,
  parameter int         GAP_QUARTERS = 4,
  parameter bit         ACK_CHECK    = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start_ov5640,
  input  logic [15:0] address_ov5640,
  input  logic [7:0]  data_ov5640,
  output logic        ready_ov5640,
  output logic        sioc,
  output logic        siod_oe,
  input  logic        siod_in,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic        ovf_err,
  input  logic        err_clr
);

  localparam int GW = (GAP_QUARTERS > 1) ? $clog2(GAP_QUARTERS) : 1;

  sccb_state_t   state_q, state_d;
  sccb_cmd_t     cmd_q [2];
  logic [1:0]    cnt_q;
  logic [31:0]   shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          sioc_q, sioc_d, siod_oe_q, siod_oe_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          ready_q, ack_err_q, ovf_err_q;
  logic          pop, push, drop, ack_set, tclr, qclr;
  logic          qtick;
  logic [1:0]    qcnt;

  sccb_qtick_gen #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk_i   (clk_sys),
    .rst_i   (reset),
    .en_i    (state_q != IDLE),
    .clr_i   (tclr),
    .qclr_i  (qclr),
    .qtick_o (qtick),
    .qcnt_o  (qcnt)
  );

  // Pop is held off while a strobe lands, so push and pop never coincide
  // and a burst of strobes fills both slots before the first is consumed.
  assign push = start_ov5640 && (cnt_q != 2'd2);
  assign drop = start_ov5640 && (cnt_q == 2'd2);

  // Command queue: head always in slot 0
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q    <= '0;
      cmd_q[0] <= '0;
      cmd_q[1] <= '0;
    end else if (pop) begin
      cmd_q[0] <= cmd_q[1];
      cnt_q    <= cnt_q - 2'd1;
    end else if (push) begin
      cmd_q[cnt_q[0]] <= '{addr: address_ov5640, data: data_ov5640};
      cnt_q           <= cnt_q + 2'd1;
    end
  end

  // Next-state and pin sequencing; every pin change is qualified by qtick
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    sioc_d     = sioc_q;
    siod_oe_d  = siod_oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ack_set    = 1'b0;
    pop        = 1'b0;
    tclr       = 1'b0;
    qclr       = 1'b0;
    case (state_q)
      IDLE: begin
        sioc_d    = 1'b1;
        siod_oe_d = 1'b0;
        if (cnt_q != 2'd0 && !start_ov5640) begin
          pop     = 1'b1;
          tclr    = 1'b1;
          shift_d = {DEV_ADDR, cmd_q[0].addr, cmd_q[0].data};
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: if (qtick) begin
        if (qcnt == 2'd0) begin
          siod_oe_d = 1'b1;
        end else begin
          qclr       = 1'b1;
          byte_cnt_d = 2'd0;
          bit_cnt_d  = 3'd7;
          state_d    = BIT;
        end
      end
      BIT: if (qtick) begin
        case (qcnt)
          2'd0: sioc_d    = 1'b0;
          2'd1: siod_oe_d = ~shift_q[31];
          2'd2: sioc_d    = 1'b1;
          default: begin
            shift_d = {shift_q[30:0], 1'b0};
            if (bit_cnt_q == 3'd0) state_d = ACK;
            else                   bit_cnt_d = bit_cnt_q - 3'd1;
          end
        endcase
      end
      ACK: if (qtick) begin
        case (qcnt)
          2'd0: sioc_d    = 1'b0;
          2'd1: siod_oe_d = 1'b0;
          2'd2: sioc_d    = 1'b1;
          default: begin
            ack_set = ACK_CHECK && siod_in;
            if (byte_cnt_q == 2'(SCCB_BYTES - 1)) begin
              state_d = STOP;
            end else begin
              byte_cnt_d = byte_cnt_q + 2'd1;
              bit_cnt_d  = 3'd7;
              state_d    = BIT;
            end
          end
        endcase
      end
      STOP: if (qtick) begin
        case (qcnt)
          2'd0: begin
            sioc_d    = 1'b0;
            siod_oe_d = 1'b1;
          end
          2'd1: sioc_d = 1'b1;
          default: begin
            siod_oe_d = 1'b0;
            qclr      = 1'b1;
            gap_cnt_d = '0;
            state_d   = GAP;
          end
        endcase
      end
      GAP: if (qtick) begin
        if (gap_cnt_q == GW'(GAP_QUARTERS - 1)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Engine state and pin registers; reset releases the bus immediately
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      sioc_q     <= 1'b1;
      siod_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      sioc_q     <= sioc_d;
      siod_oe_q  <= siod_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Handshake and sticky error flags; a new error beats a same-cycle clear
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ready_q   <= 1'b0;
      ack_err_q <= 1'b0;
      ovf_err_q <= 1'b0;
    end else begin
      ready_q   <= (cnt_q == 2'd0) && (state_q == IDLE) && !start_ov5640;
      ack_err_q <= ack_set || (ack_err_q && !err_clr);
      ovf_err_q <= drop || (ovf_err_q && !err_clr);
    end
  end

  assign ready_ov5640 = ready_q;
  assign sioc         = sioc_q;
  assign siod_oe      = siod_oe_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign ack_err      = ack_err_q;
  assign ovf_err      = ovf_err_q;

endmodule

// File: tb/tb_sccb_master_ov5640.sv
// Directed bench: SCCB slave model with ACK drive, protocol checker, and a
// second ACK_CHECK=0 instance with no slave (every X bit reads high).
`timescale 1ns/1ps
module tb_sccb_master_ov5640;

  localparam int CLK_DIV = 4;
  localparam int GAPQ    = 4;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, err_clr = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  data = '0;
  logic ready, sioc, siod_oe, busy, done, ack_err, ovf_err;
  logic ready2, sioc2, siod_oe2, busy2, done2, ack_err2, ovf_err2;
  logic slv_low = 1'b0;
  logic siod, siod_in2;

  assign siod     = ~(siod_oe | slv_low);
  assign siod_in2 = ~siod_oe2;

  int ntest = 0, nfail = 0;

  always #5 clk = ~clk;

  sccb_master_ov5640 #(.CLK_DIV(CLK_DIV), .DEV_ADDR(8'h78), .GAP_QUARTERS(GAPQ), .ACK_CHECK(1'b1)) dut (
    .clk_sys(clk), .reset(reset), .start_ov5640(start), .address_ov5640(addr), .data_ov5640(data),
    .ready_ov5640(ready), .sioc(sioc), .siod_oe(siod_oe), .siod_in(siod), .busy(busy), .done(done),
    .ack_err(ack_err), .ovf_err(ovf_err), .err_clr(err_clr));

  sccb_master_ov5640 #(.CLK_DIV(CLK_DIV), .DEV_ADDR(8'h78), .GAP_QUARTERS(GAPQ), .ACK_CHECK(1'b0)) dut2 (
    .clk_sys(clk), .reset(reset), .start_ov5640(start), .address_ov5640(addr), .data_ov5640(data),
    .ready_ov5640(ready2), .sioc(sioc2), .siod_oe(siod_oe2), .siod_in(siod_in2), .busy(busy2), .done(done2),
    .ack_err(ack_err2), .ovf_err(ovf_err2), .err_clr(err_clr));

  // Slave / protocol monitor state
  int  cyc = 0, bitn = 0, nbytes = 0, high_len = 0, low_len = 0, last_low = 0;
  int  prot_err = 0, ntx = 0, t_busy = 0, t_done = 0, last_stop_t = 0, last_gap = 0;
  int  nack_byte = -1;
  bit  in_xfer = 0, first_fall = 0, have_stop = 0;
  logic prev_sioc = 1'b1, prev_siod = 1'b1, prev_busy = 1'b0;
  logic [7:0] sh = '0;
  logic [7:0] cur [4];
  logic [7:0] txb [16][4];
  int         txn [16];

  always @(negedge clk) begin : mon
    logic pad;
    cyc++;
    if (busy && !prev_busy) t_busy = cyc;
    if (done) t_done = cyc;
    prev_busy = busy;
    if (reset) begin
      in_xfer = 0; slv_low = 1'b0; bitn = 0; nbytes = 0;
    end else begin
      pad = siod;
      if (prev_sioc && sioc && prev_siod && !pad) begin
        if (in_xfer) prot_err++;
        if (have_stop) last_gap = cyc - last_stop_t;
        in_xfer = 1; bitn = 0; nbytes = 0; first_fall = 1;
      end else if (prev_sioc && sioc && !prev_siod && pad) begin
        if (!in_xfer || last_low != CLK_DIV) prot_err++;
        if (in_xfer && ntx < 16) begin
          for (int k = 0; k < 4; k++) txb[ntx][k] = cur[k];
          txn[ntx] = nbytes;
          ntx++;
        end
        in_xfer = 0; have_stop = 1; last_stop_t = cyc;
      end
      if (!prev_sioc && sioc) begin
        last_low = low_len;
        if (in_xfer) begin
          if (bitn < 8) begin
            sh = {sh[6:0], pad};
            bitn++;
          end else begin
            if (nbytes < 4) cur[nbytes] = sh;
            nbytes++;
            bitn = 0;
          end
        end
      end
      if (prev_sioc && !sioc) begin
        if (in_xfer && !first_fall && (high_len != 2*CLK_DIV || last_low != 2*CLK_DIV)) prot_err++;
        first_fall = 0;
        if (slv_low) slv_low = 1'b0;
        else if (in_xfer && bitn == 8 && nbytes != nack_byte) slv_low = 1'b1;
      end
    end
    if (sioc) high_len = prev_sioc ? high_len + 1 : 1;
    else      low_len  = prev_sioc ? 1 : low_len + 1;
    prev_sioc = sioc;
    prev_siod = ~(siod_oe | slv_low);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [7:0] d);
    start = 1'b1; addr = a; data = d;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns at the negedge where done is seen
  task automatic wait_done(input string tag, input int budget);
    bit ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  function automatic logic [31:0] txw(input int i);
    return {txb[i][0], txb[i][1], txb[i][2], txb[i][3]};
  endfunction

  initial begin : stim
    int base;
    bit ok;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_sioc", 32'(sioc), 32'd1);
    chk("rst_siod_oe", 32'(siod_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ack_err", 32'(ack_err), 32'd0);
    chk("rst_ovf_err", 32'(ovf_err), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("ready_after_rst", 32'(ready), 32'd1);

    // 1: single write, latency and decode
    base = ntx;
    send(16'h3008, 8'h82);
    wait_done("t1_done", 1500);
    chk("t1_ready_at_done", 32'(ready), 32'd0);
    @(negedge clk);
    chk("t1_ready_next", 32'(ready), 32'd1);
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_latency", 32'(t_done - t_busy), 32'd612);
    chk("t1_ntx", 32'(ntx - base), 32'd1);
    chk("t1_nbytes", 32'(txn[base]), 32'd4);
    chk("t1_bytes", txw(base), 32'h78300882);
    chk("t1_ack_err", 32'(ack_err), 32'd0);

    // 2: two back-to-back strobes, both executed in order with a bus-free gap
    base = ntx;
    send(16'h3103, 8'h11);
    send(16'h3008, 8'h02);
    wait_done("t2_done_a", 1500);
    wait_done("t2_done_b", 1500);
    @(negedge clk);
    chk("t2_ntx", 32'(ntx - base), 32'd2);
    chk("t2_bytes_a", txw(base), 32'h78310311);
    chk("t2_bytes_b", txw(base + 1), 32'h78300802);
    chk("t2_gap_ge16", 32'(last_gap >= 16), 32'd1);
    chk("t2_ovf_err", 32'(ovf_err), 32'd0);

    // 3: three strobes, third dropped; err_clr with the drop loses
    base = ntx;
    send(16'h3a00, 8'h01);
    send(16'h3a01, 8'h02);
    err_clr = 1'b1;
    send(16'h3a02, 8'h03);
    err_clr = 1'b0;
    @(negedge clk);
    chk("t3_ovf_set", 32'(ovf_err), 32'd1);
    wait_done("t3_done_a", 1500);
    wait_done("t3_done_b", 1500);
    repeat (700) @(negedge clk);
    chk("t3_ntx", 32'(ntx - base), 32'd2);
    chk("t3_idle", 32'(busy), 32'd0);
    chk("t3_bytes_a", txw(base), 32'h783a0001);
    chk("t3_bytes_b", txw(base + 1), 32'h783a0102);
    err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("t3_ovf_clr", 32'(ovf_err), 32'd0);

    // 4: NACK on byte index 2; sticky ack_err; ACK_CHECK=0 instance ignores X bits
    base = ntx;
    nack_byte = 2;
    send(16'h3100, 8'h55);
    wait_done("t4_done_a", 1500);
    @(negedge clk);
    chk("t4_ack_err", 32'(ack_err), 32'd1);
    chk("t4_bytes_a", txw(base), 32'h78310055);
    chk("t4_ack_err_nochk", 32'(ack_err2), 32'd0);
    nack_byte = -1;
    send(16'h3101, 8'h66);
    wait_done("t4_done_b", 1500);
    @(negedge clk);
    chk("t4_ack_sticky", 32'(ack_err), 32'd1);
    chk("t4_bytes_b", txw(base + 1), 32'h78310166);
    err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("t4_ack_clr", 32'(ack_err), 32'd0);

    // 5: reset mid-BIT of byte 1 with a second command queued
    send(16'h3104, 8'hAA);
    send(16'h3105, 8'hBB);
    ok = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (in_xfer && nbytes == 1 && bitn == 3) begin ok = 1; break; end
    end
    chk("t5_mid_bit", 32'(ok), 32'd1);
    base = ntx;
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("t5_sioc", 32'(sioc), 32'd1);
    chk("t5_siod_oe", 32'(siod_oe), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ready_in_rst", 32'(ready), 32'd0);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("t5_ready_after", 32'(ready), 32'd1);
    repeat (50) @(negedge clk);
    chk("t5_no_restart", 32'(busy), 32'd0);
    chk("t5_no_tx", 32'(ntx - base), 32'd0);
    send(16'h3017, 8'hFF);
    wait_done("t5_done", 1500);
    @(negedge clk);
    chk("t5_bytes", txw(base), 32'h783017FF);
    chk("t5_ack_err", 32'(ack_err), 32'd0);

    // Protocol checker verdict and no-check instance
    chk("protocol", 32'(prot_err), 32'd0);
    chk("ack_err_nochk_end", 32'(ack_err2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
